// File: rtl/ultrasonic_pkg.sv
// ultrasonic_pkg
// Shared types and default timing constants for the ultrasonic obstacle
// monitor: distance class type, monitor FSM state encoding, and the
// saturating run-counter type used by the filter and the timeout tracker.
package ultrasonic_pkg;

    typedef logic [2:0] obst_t;
    localparam obst_t OBST_NONE = 3'd0;

    typedef enum logic [1:0] {
        IDLE,
        TRIGGER,
        WAIT_VALID,
        HOLDOFF
    } mon_state_t;

    // 100 MHz defaults: 60 ms period, 30 ms timeout
    localparam int DEF_PERIOD_CYCLES  = 6_000_000;
    localparam int DEF_TIMEOUT_CYCLES = 3_000_000;
    localparam int DEF_CONFIRM_N      = 3;
    localparam int DEF_STOP_LEVEL     = 4;

    // Run counters (filter confirmation, consecutive timeouts) are 4 bits
    typedef logic [3:0] run_t;
    localparam run_t RUN_MAX = 4'd15;

endpackage

// File: rtl/obst_filter.sv
// obst_filter
// Fast-attack / slow-release filter on the obstacle distance class.
// A reading above the current level is taken at once; a lower reading must
// repeat CONFIRM_N times in a row before the level drops to it.
// Ports:
//   clk, reset     clock, synchronous active-low reset
//   sample_en      one-cycle strobe: sample holds an accepted reading
//   sample         distance class reading
//   level          filtered distance class (registered)
module obst_filter
    import ultrasonic_pkg::*;
#(
    parameter int CONFIRM_N = DEF_CONFIRM_N
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  sample_en,
    input  obst_t sample,
    output obst_t level
);

    localparam run_t CONFIRM = run_t'(CONFIRM_N);

    obst_t level_q, level_d;
    obst_t cand_q, cand_d;
    run_t  run_q, run_d;
    run_t  run_nxt;

    always_comb begin
        level_d = level_q;
        cand_d  = cand_q;
        run_d   = run_q;
        run_nxt = '0;
        if (sample_en) begin
            if (sample > level_q) begin
                level_d = sample;
                run_d   = '0;
            end else if (sample == level_q) begin
                run_d = '0;
            end else begin
                // A different lower value restarts the confirmation run
                run_nxt = (sample == cand_q) ? run_q + 4'd1 : 4'd1;
                cand_d  = sample;
                if (run_nxt >= CONFIRM) begin
                    level_d = sample;
                    run_d   = '0;
                end else begin
                    run_d = run_nxt;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            level_q <= OBST_NONE;
            cand_q  <= OBST_NONE;
            run_q   <= '0;
        end else begin
            level_q <= level_d;
            cand_q  <= cand_d;
            run_q   <= run_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/obstacle_monitor.sv
// obstacle_monitor
// Schedules periodic ultrasonic measurements, filters the returned distance
// class and raises a fail-safe stop after repeated missing measurements.
// Ports:
//   clk, reset         clock, synchronous active-low reset
//   enable             run periodic measurements
//   ultrasonic_valid   measurement complete (only honoured in WAIT_VALID)
//   obst               distance class, 0 = none, 7 = closest
//   start_ultrasonic   one-cycle measurement request
//   obstacle_level     filtered distance class
//   obstacle_stop      level >= STOP_LEVEL, or fail-safe
//   fail_safe          CONFIRM_N consecutive timeouts
//   sample_timeout     one-cycle pulse on a timed-out measurement
// All outputs are registered.
module obstacle_monitor
    import ultrasonic_pkg::*;
#(
    parameter int PERIOD_CYCLES  = DEF_PERIOD_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CONFIRM_N      = DEF_CONFIRM_N,
    parameter int STOP_LEVEL     = DEF_STOP_LEVEL
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       ultrasonic_valid,
    input  logic [2:0] obst,
    output logic       start_ultrasonic,
    output logic [2:0] obstacle_level,
    output logic       obstacle_stop,
    output logic       fail_safe,
    output logic       sample_timeout
);

    localparam int            CW      = (PERIOD_CYCLES > 2) ? $clog2(PERIOD_CYCLES) : 1;
    localparam logic [CW-1:0] P_LAST  = CW'(PERIOD_CYCLES - 1);
    localparam logic [CW-1:0] T_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    STOP_L  = 4'(STOP_LEVEL);
    localparam run_t          CONFIRM = run_t'(CONFIRM_N);

    mon_state_t    state_q, state_d;
    logic [CW-1:0] pcnt_q, pcnt_d;   // cycles since the start pulse
    logic [CW-1:0] tcnt_q, tcnt_d;   // cycles waited for valid
    run_t          trun_q, trun_d;   // consecutive timeouts, saturating
    logic          accept;
    logic          tout_d;
    logic          fs_now;
    obst_t         filt_level;

    logic          start_q, tout_q, stop_q, fs_q;
    obst_t         lvl_q;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        tout_d  = 1'b0;
        trun_d  = trun_q;
        case (state_q)
            IDLE: begin
                if (enable) state_d = TRIGGER;
            end
            TRIGGER: begin
                state_d = WAIT_VALID;
            end
            WAIT_VALID: begin
                // A valid on the last wait cycle beats the timeout
                if (ultrasonic_valid) begin
                    accept  = 1'b1;
                    trun_d  = '0;
                    state_d = HOLDOFF;
                end else if (tcnt_q == T_LAST) begin
                    tout_d  = 1'b1;
                    if (trun_q != RUN_MAX) trun_d = trun_q + 4'd1;
                    state_d = HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (pcnt_q == P_LAST) state_d = enable ? TRIGGER : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Both counters read 0 in the TRIGGER cycle, so the next start lands
    // exactly PERIOD_CYCLES later and the timeout pulse TIMEOUT_CYCLES later.
    always_comb begin
        pcnt_d = pcnt_q;
        tcnt_d = tcnt_q;
        if (state_d == TRIGGER) begin
            pcnt_d = '0;
            tcnt_d = '0;
        end else begin
            if (state_q != IDLE && pcnt_q != P_LAST)
                pcnt_d = pcnt_q + 1'b1;
            if ((state_q == TRIGGER || state_q == WAIT_VALID) && tcnt_q != T_LAST)
                tcnt_d = tcnt_q + 1'b1;
        end
    end

    assign fs_now = (trun_q >= CONFIRM);

    obst_filter #(
        .CONFIRM_N (CONFIRM_N)
    ) u_filter (
        .clk       (clk),
        .reset     (reset),
        .sample_en (accept),
        .sample    (obst),
        .level     (filt_level)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            pcnt_q  <= '0;
            tcnt_q  <= '0;
            trun_q  <= '0;
            start_q <= 1'b0;
            tout_q  <= 1'b0;
            lvl_q   <= OBST_NONE;
            stop_q  <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            tcnt_q  <= tcnt_d;
            trun_q  <= trun_d;
            start_q <= (state_d == TRIGGER);
            tout_q  <= tout_d;
            lvl_q   <= filt_level;
            stop_q  <= ({1'b0, filt_level} >= STOP_L) || fs_now;
            fs_q    <= fs_now;
        end
    end

    assign start_ultrasonic = start_q;
    assign sample_timeout   = tout_q;
    assign obstacle_level   = lvl_q;
    assign obstacle_stop    = stop_q;
    assign fail_safe        = fs_q;

endmodule

// File: tb/tb_obstacle_monitor.sv
// tb_obstacle_monitor
// Directed bench: a table of per-measurement vectors (valid reading or
// timeout, with expected level / stop / fail-safe), then hand-written
// sequences for holdoff valids, coincident valid, enable drop and reset.
module tb_obstacle_monitor;

    localparam int P  = 100;
    localparam int TO = 60;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       ultrasonic_valid;
    logic [2:0] obst;
    logic       start_ultrasonic;
    logic [2:0] obstacle_level;
    logic       obstacle_stop;
    logic       fail_safe;
    logic       sample_timeout;

    obstacle_monitor #(
        .PERIOD_CYCLES  (P),
        .TIMEOUT_CYCLES (TO),
        .CONFIRM_N      (3),
        .STOP_LEVEL     (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .ultrasonic_valid (ultrasonic_valid),
        .obst             (obst),
        .start_ultrasonic (start_ultrasonic),
        .obstacle_level   (obstacle_level),
        .obstacle_stop    (obstacle_stop),
        .fail_safe        (fail_safe),
        .sample_timeout   (sample_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         v;     // 1: valid reading at start+20, 0: no valid
        logic [2:0] o;     // reading
        logic [2:0] lvl;   // expected level after the measurement
        bit         stop;
        bit         fs;
    } vec_t;

    vec_t vecs [15];

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int t_start = 0;
    int t_prev = 0;
    int n;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic wait_start(output int t);
        int k;
        k = 0;
        while (start_ultrasonic !== 1'b1 && k < 300) begin
            tick();
            k++;
        end
        chk("start_seen", {31'd0, start_ultrasonic}, 32'd1);
        t = cyc;
    endtask

    task automatic chk_outs(input string nm, input logic [2:0] lvl, input bit stop, input bit fs);
        chk({nm, "_level"}, {29'd0, obstacle_level}, {29'd0, lvl});
        chk({nm, "_stop"},  {31'd0, obstacle_stop},  {31'd0, stop});
        chk({nm, "_fs"},    {31'd0, fail_safe},      {31'd0, fs});
    endtask

    initial begin
        vecs[0]  = '{1'b1, 3'd2, 3'd2, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 3'd5, 3'd5, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 3'd1, 3'd5, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 3'd1, 3'd5, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 3'd1, 3'd1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 3'd5, 3'd5, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 3'd1, 3'd5, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 3'd3, 3'd5, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 3'd1, 3'd5, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 3'd1, 3'd5, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 3'd1, 3'd1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 3'd0, 3'd1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 3'd0, 3'd1, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 3'd0, 3'd1, 1'b1, 1'b1};
        vecs[14] = '{1'b1, 3'd0, 3'd1, 1'b0, 1'b0};

        reset = 1'b0;
        enable = 1'b0;
        ultrasonic_valid = 1'b0;
        obst = 3'd0;
        ticks(3);
        chk_outs("reset", 3'd0, 1'b0, 1'b0);
        chk("reset_start", {31'd0, start_ultrasonic}, 32'd0);
        chk("reset_tout", {31'd0, sample_timeout}, 32'd0);
        reset = 1'b1;
        tick();
        enable = 1'b1;

        // Table: one measurement per vector
        for (int i = 0; i < 15; i++) begin
            wait_start(t_start);
            if (i > 0) chk("period", t_start - t_prev, P);
            t_prev = t_start;
            if (vecs[i].v) begin
                ticks(20);
                ultrasonic_valid = 1'b1;
                obst = vecs[i].o;
                tick();
                ultrasonic_valid = 1'b0;
                tick();
                chk_outs($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].stop, vecs[i].fs);
            end else begin
                ticks(TO - 1);
                chk($sformatf("vec%0d_tout_early", i), {31'd0, sample_timeout}, 32'd0);
                tick();
                chk($sformatf("vec%0d_tout", i), {31'd0, sample_timeout}, 32'd1);
                tick();
                chk($sformatf("vec%0d_tout_end", i), {31'd0, sample_timeout}, 32'd0);
                chk_outs($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].stop, vecs[i].fs);
            end
        end

        // Valid during HOLDOFF is ignored (level 1 would jump to 7)
        wait_start(t_start);
        chk("period_hold", t_start - t_prev, P);
        t_prev = t_start;
        ticks(10);
        ultrasonic_valid = 1'b1;
        obst = 3'd1;
        tick();
        ultrasonic_valid = 1'b0;
        ticks(19);
        ultrasonic_valid = 1'b1;
        obst = 3'd7;
        tick();
        ultrasonic_valid = 1'b0;
        ticks(2);
        chk_outs("holdoff_valid", 3'd1, 1'b0, 1'b0);

        // Valid on the last wait cycle wins over the timeout
        wait_start(t_start);
        chk("period_coinc", t_start - t_prev, P);
        t_prev = t_start;
        ticks(TO - 1);
        ultrasonic_valid = 1'b1;
        obst = 3'd6;
        tick();
        ultrasonic_valid = 1'b0;
        chk("coinc_no_tout", {31'd0, sample_timeout}, 32'd0);
        tick();
        chk_outs("coinc", 3'd6, 1'b1, 1'b0);

        // Enable dropped mid-wait: measurement completes, no further start
        wait_start(t_start);
        chk("period_endrop", t_start - t_prev, P);
        ticks(5);
        enable = 1'b0;
        ticks(15);
        ultrasonic_valid = 1'b1;
        obst = 3'd7;
        tick();
        ultrasonic_valid = 1'b0;
        tick();
        chk_outs("endrop", 3'd7, 1'b1, 1'b0);
        n = 0;
        for (int i = 0; i < 250; i++) begin
            tick();
            if (start_ultrasonic) n++;
        end
        chk("endrop_no_start", n, 0);

        // Enable -> start on the next cycle; reset mid-wait clears everything
        enable = 1'b1;
        tick();
        chk("start_latency", {31'd0, start_ultrasonic}, 32'd1);
        ticks(10);
        reset = 1'b0;
        enable = 1'b0;
        tick();
        chk_outs("midreset", 3'd0, 1'b0, 1'b0);
        chk("midreset_start", {31'd0, start_ultrasonic}, 32'd0);
        reset = 1'b1;
        n = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (start_ultrasonic || sample_timeout) n++;
        end
        chk("postreset_quiet", n, 0);
        enable = 1'b1;
        tick();
        chk("restart", {31'd0, start_ultrasonic}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/obstacle_monitor.md
# obstacle_monitor

Schedules periodic ultrasonic measurements and turns the raw `obst` class into a stable obstacle level for the robot's motion control. It sits directly upstream and downstream of the ultrasonic controller: it drives `start_ultrasonic`, consumes `obst`/`ultrasonic_valid`, and filters the readings. Escalations are accepted fast and releases slowly, and repeated missing measurements force a fail-safe stop.

## Interface
- `PERIOD_CYCLES`, default 6_000_000: cycles between successive start pulses (60 ms at 100 MHz).
- `TIMEOUT_CYCLES`, default 3_000_000: maximum wait for `ultrasonic_valid` after a start pulse; must be < `PERIOD_CYCLES`.
- `CONFIRM_N`, default 3: consecutive identical readings needed to lower the level; also the consecutive-timeout count that triggers fail-safe; range 1–15.
- `STOP_LEVEL`, default 4: `obstacle_stop` asserts when the level is ≥ this value.
- `clk` in 1: system clock; the block uses only this clock.
- `reset` in 1: synchronous, active-low.
- `enable` in 1: run periodic measurements.
- `ultrasonic_valid` in 1: measurement-complete indication from the ultrasonic controller.
- `obst` in 3: distance class; 0 = none, 7 = closest.
- `start_ultrasonic` out 1: one-cycle measurement request.
- `obstacle_level` out 3: filtered distance class.
- `obstacle_stop` out 1: (`obstacle_level` ≥ `STOP_LEVEL`) OR `fail_safe`.
- `fail_safe` out 1: `CONFIRM_N` consecutive timeouts have occurred.
- `sample_timeout` out 1: one-cycle pulse when a measurement times out.

## Operation
- FSM states: IDLE, TRIGGER, WAIT_VALID, HOLDOFF.
  - IDLE: if `enable`=1, go to TRIGGER.
  - TRIGGER: `start_ultrasonic`=1 for this cycle only; clear the period and timeout counters; go to WAIT_VALID.
  - WAIT_VALID: on the first cycle with `ultrasonic_valid`=1, capture `obst`, update the filter, clear the timeout run counter, and go to HOLDOFF. If the timeout counter reaches `TIMEOUT_CYCLES`-1 with no valid, pulse `sample_timeout`, increment the timeout run counter (saturating at 15), leave the filter unchanged, and go to HOLDOFF.
  - HOLDOFF: when the period counter reaches `PERIOD_CYCLES`-1, go to TRIGGER if `enable`=1, else IDLE.
- `ultrasonic_valid` is ignored in IDLE, TRIGGER and HOLDOFF; stale or late valids are discarded.
- If `enable` drops mid-measurement, the measurement still completes (valid or timeout); the FSM returns to IDLE at the end of the period.
- Valid and timeout in the same cycle: the valid wins, and no timeout is counted.
- Filter (registers `level`, `cand`, `run`):
  - Reading > `level`: `level` ← reading immediately; `run` ← 0.
  - Reading == `level`: `run` ← 0.
  - Reading < `level`: if reading == `cand`, `run`++; otherwise `cand` ← reading and `run` ← 1. When `run` reaches `CONFIRM_N`, `level` ← `cand` and `run` ← 0.
- `fail_safe` = timeout run counter ≥ `CONFIRM_N`. It clears on the next accepted valid.
- Counters are unsigned, sized $clog2(`PERIOD_CYCLES`) bits, and never wrap inside a period.

## Timing
- Reset (`reset`=0 at a clk edge): state IDLE; all outputs 0; `level`/`cand`/`run`, the counters and the timeout run counter are cleared. Reset mid-measurement aborts it with no start pulse.
- `enable` high at edge k in IDLE → `start_ultrasonic` high during cycle k+1.
- While `enable` is held, start pulses are exactly `PERIOD_CYCLES` cycles apart.
- Valid sampled at edge k → `obstacle_level`, `obstacle_stop` and `fail_safe` update at edge k+1.
- `sample_timeout` is high exactly `TIMEOUT_CYCLES` cycles after the start pulse; `fail_safe` rises one cycle after the `CONFIRM_N`th such pulse.
- All outputs are registered.

## Structure
- Package `ultrasonic_pkg`:
  - `obst_t` (logic [2:0]) and `OBST_NONE`=0.
  - `mon_state_t` enum {IDLE, TRIGGER, WAIT_VALID, HOLDOFF}.
  - Default timing constants.
- Sub-module `obst_filter` holds the fast-attack/slow-release logic: inputs `sample_en`, `sample`; output `level`; parameter `CONFIRM_N`.
- The top level holds the FSM, the counters, the timeout run counter and the output logic.

## Test plan
All scenarios use `PERIOD_CYCLES`=100, `TIMEOUT_CYCLES`=60, `CONFIRM_N`=3, `STOP_LEVEL`=4.
- Enable held, valid returned 20 cycles after each start with `obst`=2 → start pulses 100 cycles apart; `obstacle_level`=2 one cycle after the first valid; `obstacle_stop`=0.
- Level 2, then a single reading of 5 → level 5 and `obstacle_stop`=1 on the next cycle. Readings 1,1 → level stays 5; a third 1 → level 1 and stop=0. Readings 1,3,1,1 from level 5 → still 5, because the sequence restarted.
- No valid for 3 periods → `sample_timeout` pulses 60 cycles after each start; `fail_safe`=`obstacle_stop`=1 after the third. One valid with `obst`=0 → `fail_safe`=0.
- Valid pulses during HOLDOFF, and valid coincident with the 60th wait cycle → HOLDOFF valid ignored; coincident valid accepted with no timeout pulse.
- `enable` dropped during WAIT_VALID → measurement completes and no further start pulse occurs. `reset`=0 mid-WAIT_VALID → all outputs 0 next cycle; restart requires `enable`.
